regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with write-to-read bypass and a per-register pending-write scoreboard. It replaces the fixed 32×32, two-read-port register file in the core's decode/register-read stage. Depth, width and read-port count are generics, and each read port has its own enable. The scoreboard lets the issue logic see in-flight destination registers without a separate hazard unit.

---
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with write bypass and pending-write scoreboard
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_X0 = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                claim_en,
    input  logic [AW-1:0]       claim_addr,
    input  logic                flush
);

    localparam int DEPTH = 1 << AW;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             wr_ok;

    // Register 0 is hard-wired when ZERO_X0 is set, so writes to it are dropped.
    assign wr_ok = we && !((ZERO_X0 != 0) && (wr_addr == '0));

    // Pending next state: flush beats claim, claim beats a same-cycle write-back.
    always_comb begin
        pend_nxt = pend;
        for (int r = 0; r < DEPTH; r++) begin
            if (flush) begin
                pend_nxt[r] = 1'b0;
            end else if (claim_en && (claim_addr == AW'(r))) begin
                pend_nxt[r] = 1'b1;
            end else if (we && (wr_addr == AW'(r))) begin
                pend_nxt[r] = 1'b0;
            end
            if ((ZERO_X0 != 0) && (r == 0)) begin
                pend_nxt[r] = 1'b0;
            end
        end
    end

    // Storage array update from the single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pending-bit scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d_nxt;
        logic [XLEN-1:0] d_q;
        logic            b_q;

        assign a = rd_addr[p*AW +: AW];

        // Read source select: zero register, then write-first bypass, then array.
        always_comb begin
            if ((ZERO_X0 != 0) && (a == '0)) begin
                d_nxt = '0;
            end else if (we && (wr_addr == a)) begin
                d_nxt = wr_data;
            end else begin
                d_nxt = mem[a];
            end
        end

        // Registered read data and busy flag; both hold while the port is idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
                b_q <= 1'b0;
            end else if (rd_en[p]) begin
                d_q <= d_nxt;
                b_q <= pend_nxt[a];
            end
        end

        assign rd_data[p*XLEN +: XLEN] = d_q;
        assign rd_busy[p]              = b_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, both ZERO_X0 settings
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRD-1:0]    rd_en = '0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic              we = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [XLEN-1:0]   wr_data = '0;
    logic              claim_en = 1'b0;
    logic [AW-1:0]     claim_addr = '0;
    logic              flush = 1'b0;

    logic [NRD*XLEN-1:0] rdd_z, rdd_n;
    logic [NRD-1:0]      rdb_z, rdb_n;

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_X0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd_z), .rd_busy(rdb_z), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
    );

    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_X0(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd_n), .rd_busy(rdb_n), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*XLEN-1:0] dz;
        logic [NRD*XLEN-1:0] dn;
        logic [NRD-1:0]      bz;
        logic [NRD-1:0]      bn;
    } exp_t;

    exp_t sb_q[$];

    // Reference state; index 0 models ZERO_X0=1, index 1 models ZERO_X0=0.
    logic [XLEN-1:0] m_mem [2][DEPTH];
    logic            m_pend[2][DEPTH];
    logic [XLEN-1:0] m_d   [2][NRD];
    logic            m_b   [2][NRD];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_mem[z][r]  = '0;
                m_pend[z][r] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                m_d[z][p] = '0;
                m_b[z][p] = 1'b0;
            end
        end
    endtask

    task automatic set_idle();
        rd_en = '0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    endtask

    // Apply one cycle of the register-file rules to the reference state.
    task automatic model_step();
        logic np[2][DEPTH];
        int   a;
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (flush)                                 np[z][r] = 1'b0;
                else if (claim_en && int'(claim_addr) == r) np[z][r] = 1'b1;
                else if (we && int'(wr_addr) == r)         np[z][r] = 1'b0;
                else                                       np[z][r] = m_pend[z][r];
                if (z == 0 && r == 0) np[z][r] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    if (z == 0 && a == 0)                m_d[z][p] = '0;
                    else if (we && int'(wr_addr) == a)   m_d[z][p] = wr_data;
                    else                                 m_d[z][p] = m_mem[z][a];
                    m_b[z][p] = np[z][a];
                end
            end
            if (we && !(z == 0 && wr_addr == '0)) m_mem[z][wr_addr] = wr_data;
            for (int r = 0; r < DEPTH; r++) m_pend[z][r] = np[z][r];
        end
    endtask

    task automatic cyc(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic c, input logic [4:0] ca, input logic f);
        exp_t e;
        @(negedge clk);
        rd_en = en; rd_addr = {a1, a0}; we = w; wr_addr = wa; wr_data = wd;
        claim_en = c; claim_addr = ca; flush = f;
        model_step();
        for (int p = 0; p < NRD; p++) begin
            e.dz[p*XLEN +: XLEN] = m_d[0][p];
            e.dn[p*XLEN +: XLEN] = m_d[1][p];
            e.bz[p] = m_b[0][p];
            e.bn[p] = m_b[1][p];
        end
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are presented one cycle after each issued vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int p = 0; p < NRD; p++) begin
                    chk($sformatf("zx1_data_p%0d", p), rdd_z[p*XLEN +: XLEN], e.dz[p*XLEN +: XLEN]);
                    chk($sformatf("zx1_busy_p%0d", p), 32'(rdb_z[p]), 32'(e.bz[p]));
                    chk($sformatf("zx0_data_p%0d", p), rdd_n[p*XLEN +: XLEN], e.dn[p*XLEN +: XLEN]);
                    chk($sformatf("zx0_busy_p%0d", p), 32'(rdb_n[p]), 32'(e.bn[p]));
                end
            end
        end
    end

    initial begin
        set_idle();
        model_reset();
        #12;
        chk("reset_data_zx1", rdd_z[31:0] | rdd_z[63:32], 32'h0);
        chk("reset_busy_zx1", 32'(rdb_z), 32'h0);
        chk("reset_data_zx0", rdd_n[31:0] | rdd_n[63:32], 32'h0);
        chk("reset_busy_zx0", 32'(rdb_n), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read, with an unwritten neighbour.
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        cyc(2'b11, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        // Bypass on every port.
        cyc(2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0);
        // Register 0 write and claim, bypass case then stored case.
        cyc(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
        cyc(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        // Scoreboard: claim, write-back, claim+write, flush+claim.
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 1'b0);
        cyc(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'h00000034, 1'b1, 5'd3, 1'b0);
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1);
        // Port 1 hold while its address and target change underneath it.
        cyc(2'b11, 5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        cyc(2'b01, 5'd5, 5'd10, 1'b1, 5'd10, 32'hCAFE0010, 1'b1, 5'd10, 1'b0);
        cyc(2'b01, 5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc(2'b11, 5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

        // Random traffic on a narrow address window to force collisions.
        for (int i = 0; i < 1500; i++) begin
            cyc(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0));
        end

        // Nonzero data and busy on both ports, then asynchronous reset mid-cycle.
        cyc(2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        set_idle();
        #1;
        chk("async_rst_data_zx1", rdd_z[31:0] | rdd_z[63:32], 32'h0);
        chk("async_rst_busy_zx1", 32'(rdb_z), 32'h0);
        chk("async_rst_data_zx0", rdd_n[31:0] | rdd_n[63:32], 32'h0);
        chk("async_rst_busy_zx0", 32'(rdb_n), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            cyc(2'b11, 5'(2 * i), 5'(2 * i + 1), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
